// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants for the register file / write-back block.
//   Load funct3 encodings (RISC-V style) and the LUI immediate shift.
package regfile_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // LUI places its 20-bit immediate above this many zero bits.
  localparam int LUI_SHIFT = 12;

endpackage

// File: rtl/regfile_wb_load_align.sv
// load_align: combinational load-data lane select and sign/zero extension.
//   funct3  in  3     load type (LB/LH/LW/LBU/LHU, others pass full word)
//   addr_lo in  2     low address bits: byte lane, bit 1 selects half lane
//   rdata   in  XLEN  raw word returned by data memory
//   result  out XLEN  aligned, extended value to write back
module load_align
  import regfile_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = rdata[{addr_lo, 3'b000} +: 8];
  assign half_s = rdata[{addr_lo[1], 4'b0000} +: 16];

  // Select lane and extend according to the load type.
  always_comb begin
    result = rdata;
    case (funct3)
      F3_LB:   result = {{(XLEN-8){byte_s[7]}}, byte_s};
      F3_LH:   result = {{(XLEN-16){half_s[15]}}, half_s};
      F3_LW:   result = rdata;
      F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_s};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, half_s};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/regfile_wb.sv
// regfile_wb: integer register file with one arbitrated write-back port,
// load scoreboard and a one-entry store-data buffer.
//   rs1/rs2_addr -> rs1/rs2_data, rs1/rs2_busy : combinational read ports
//                   (write-first bypass, x0 reads 0)
//   alu_we/alu_rd/alu_wdata                    : ALU write-back
//   lui_en/lui_rd/lui_imm                      : LUI write-back (highest priority)
//   ld_issue/ld_issue_rd                       : marks a load destination busy
//   ld_valid/ld_ready + ld_rd/funct3/addr/data : load return handshake
//   st_req/st_rs/st_req_ready                  : store data request
//   st_valid/st_data/st_ready                  : store data toward memory
module regfile_wb
  import regfile_pkg::*;
#(
  parameter int  XLEN    = 32,
  parameter int  NREG    = 32,
  parameter int  RST_IDX = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            alu_we,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_wdata,
  input  logic            lui_en,
  input  logic [AW-1:0]   lui_rd,
  input  logic [19:0]     lui_imm,
  input  logic            ld_issue,
  input  logic [AW-1:0]   ld_issue_rd,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [AW-1:0]   ld_rd,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_addr_lo,
  input  logic [XLEN-1:0] ld_rdata,
  input  logic            st_req,
  input  logic [AW-1:0]   st_rs,
  output logic            st_req_ready,
  output logic            st_valid,
  input  logic            st_ready,
  output logic [XLEN-1:0] st_data
);

  logic [XLEN-1:0] regs_r [NREG];
  logic [NREG-1:0] busy_r;
  logic [NREG-1:0] busy_next_s;
  logic            st_valid_r;
  logic [XLEN-1:0] st_data_r;

  logic [XLEN-1:0] ld_val_s;
  logic [31:0]     lui_word_s;
  logic [XLEN-1:0] lui_val_s;
  logic            ld_fire_s;
  logic            wr_en_s;
  logic [AW-1:0]   wr_rd_s;
  logic [XLEN-1:0] wr_data_s;
  logic            wr_commit_s;
  logic            st_accept_s;

  // Three bypassed read ports: rs1, rs2 and the store source.
  logic [AW-1:0]   rd_addr_s [3];
  logic [XLEN-1:0] rd_val_s  [3];

  load_align #(.XLEN(XLEN)) u_load_align (
    .funct3  (ld_funct3),
    .addr_lo (ld_addr_lo),
    .rdata   (ld_rdata),
    .result  (ld_val_s)
  );

  // Sign-extending cast also truncates cleanly when XLEN < 32.
  assign lui_word_s = {12'h000, lui_imm} << LUI_SHIFT;
  assign lui_val_s  = XLEN'($signed(lui_word_s));

  // Loads only get the port when neither execute-side source writes.
  assign ld_ready  = !(lui_en | alu_we);
  assign ld_fire_s = ld_valid & ld_ready;

  // Write arbiter: LUI over ALU over load return.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_rd_s   = '0;
    wr_data_s = '0;
    if (lui_en) begin
      wr_en_s   = 1'b1;
      wr_rd_s   = lui_rd;
      wr_data_s = lui_val_s;
    end else if (alu_we) begin
      wr_en_s   = 1'b1;
      wr_rd_s   = alu_rd;
      wr_data_s = alu_wdata;
    end else if (ld_fire_s) begin
      wr_en_s   = 1'b1;
      wr_rd_s   = ld_rd;
      wr_data_s = ld_val_s;
    end else begin
      wr_en_s   = 1'b0;
    end
  end

  assign wr_commit_s = wr_en_s && (wr_rd_s != {AW{1'b0}});

  assign rd_addr_s[0] = rs1_addr;
  assign rd_addr_s[1] = rs2_addr;
  assign rd_addr_s[2] = st_rs;

  // Read muxes with write-first bypass; x0 always reads zero.
  always_comb begin
    rd_val_s = '{default: '0};
    for (int p = 0; p < 3; p++) begin
      if (rd_addr_s[p] == {AW{1'b0}}) begin
        rd_val_s[p] = '0;
      end else if (wr_commit_s && (wr_rd_s == rd_addr_s[p])) begin
        rd_val_s[p] = wr_data_s;
      end else begin
        rd_val_s[p] = regs_r[rd_addr_s[p]];
      end
    end
  end

  assign rs1_data = rd_val_s[0];
  assign rs2_data = rd_val_s[1];
  assign rs1_busy = busy_r[rs1_addr];
  assign rs2_busy = busy_r[rs2_addr];

  // Register array storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= (RST_IDX != 0) ? XLEN'(i) : '0;
      end
    end else if (wr_commit_s) begin
      regs_r[wr_rd_s] <= wr_data_s;
    end
  end

  // Scoreboard next state: clear on completion first so a same-cycle issue wins.
  always_comb begin
    busy_next_s = busy_r;
    if (ld_fire_s) begin
      busy_next_s[ld_rd] = 1'b0;
    end else begin
      busy_next_s = busy_r;
    end
    if (ld_issue) begin
      busy_next_s[ld_issue_rd] = 1'b1;
    end else begin
      busy_next_s[0] = 1'b0;
    end
    busy_next_s[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_next_s;
    end
  end

  assign st_req_ready = !st_valid_r | st_ready;
  assign st_accept_s  = st_req & st_req_ready;

  // One-entry store buffer; data only changes on an accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_valid_r <= 1'b0;
      st_data_r  <= '0;
    end else if (st_accept_s) begin
      st_valid_r <= 1'b1;
      st_data_r  <= rd_val_s[2];
    end else if (st_ready) begin
      st_valid_r <= 1'b0;
    end
  end

  assign st_valid = st_valid_r;
  assign st_data  = st_data_r;

endmodule

// File: tb/tb_regfile_wb.sv
// Bench for regfile_wb: a directed cycle table covering the documented
// scenarios, an asynchronous reset during a stalled store, then random
// traffic compared against a rule-level reference model.
module tb_regfile_wb;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        rs1_busy, rs2_busy;
  logic        alu_we;
  logic [4:0]  alu_rd;
  logic [31:0] alu_wdata;
  logic        lui_en;
  logic [4:0]  lui_rd;
  logic [19:0] lui_imm;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic [31:0] ld_rdata;
  logic        st_req;
  logic [4:0]  st_rs;
  logic        st_req_ready, st_valid, st_ready;
  logic [31:0] st_data;

  regfile_wb #(.XLEN(32), .NREG(32), .RST_IDX(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .alu_we(alu_we), .alu_rd(alu_rd), .alu_wdata(alu_wdata),
    .lui_en(lui_en), .lui_rd(lui_rd), .lui_imm(lui_imm),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_rd(ld_rd), .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo), .ld_rdata(ld_rdata),
    .st_req(st_req), .st_rs(st_rs), .st_req_ready(st_req_ready),
    .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic        alu_we;  logic [4:0] alu_rd;  logic [31:0] alu_wdata;
    logic        lui_en;  logic [4:0] lui_rd;  logic [19:0] lui_imm;
    logic        ld_issue; logic [4:0] ld_issue_rd;
    logic        ld_valid; logic [4:0] ld_rd; logic [2:0] f3; logic [1:0] lo; logic [31:0] rdata;
    logic        st_req;  logic [4:0] st_rs;   logic st_ready;
    logic [31:0] e_rs1, e_rs2;
    logic        e_busy1, e_ldr, e_srr, e_sv;
    logic [31:0] e_sd;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t blank();
    vec_t v;
    v = '{default: '0};
    v.e_ldr = 1'b1;
    v.e_srr = 1'b1;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rs1_addr = v.rs1;  rs2_addr = v.rs2;
    alu_we = v.alu_we; alu_rd = v.alu_rd; alu_wdata = v.alu_wdata;
    lui_en = v.lui_en; lui_rd = v.lui_rd; lui_imm = v.lui_imm;
    ld_issue = v.ld_issue; ld_issue_rd = v.ld_issue_rd;
    ld_valid = v.ld_valid; ld_rd = v.ld_rd; ld_funct3 = v.f3; ld_addr_lo = v.lo; ld_rdata = v.rdata;
    st_req = v.st_req; st_rs = v.st_rs; st_ready = v.st_ready;
  endtask

  // ---------------- reference model (architectural rules) ----------------
  logic [31:0] m_reg [32];
  bit          m_busy [32];
  bit          m_sv;
  logic [31:0] m_sd;
  bit          m_we;
  logic [4:0]  m_wrd;
  logic [31:0] m_wv;

  function automatic logic [31:0] m_align(input logic [2:0] f3, input logic [1:0] lo,
                                          input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * lo)) & 32'h0000_00FF;
    h = (d >> (16 * (lo / 2))) & 32'h0000_FFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (m_we && m_wrd == a) return m_wv;
    return m_reg[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = i;
      m_busy[i] = 1'b0;
    end
    m_sv = 1'b0;
    m_sd = 32'd0;
  endtask

  initial begin
    vec_t v;
    bit   ldr, srr;

    // Row expectations are the pre-edge values of each cycle.
    v = blank(); v.rs1 = 5'd5; v.e_rs1 = 32'd5; tbl.push_back(v);
    v = blank(); v.rs1 = 5'd7; v.ld_issue = 1; v.ld_issue_rd = 5'd7; v.e_rs1 = 32'd7; tbl.push_back(v);
    v = blank(); v.rs1 = 5'd7; v.e_rs1 = 32'd7; v.e_busy1 = 1; tbl.push_back(v);
    v = blank(); v.rs1 = 5'd7; v.ld_valid = 1; v.ld_rd = 5'd7; v.f3 = F3_LB; v.lo = 2'd2;
    v.rdata = 32'h0080_0000; v.e_rs1 = 32'hFFFF_FF80; v.e_busy1 = 1; tbl.push_back(v);
    v = blank(); v.rs1 = 5'd7; v.e_rs1 = 32'hFFFF_FF80; tbl.push_back(v);
    v = blank(); v.rs1 = 5'd3; v.rs2 = 5'd8; v.alu_we = 1; v.alu_rd = 5'd3; v.alu_wdata = 32'h1234;
    v.ld_valid = 1; v.ld_rd = 5'd8; v.f3 = F3_LHU; v.lo = 2'd2; v.rdata = 32'h8001_0000;
    v.e_rs1 = 32'h1234; v.e_rs2 = 32'd8; v.e_ldr = 0; tbl.push_back(v);
    v.alu_we = 0; v.e_rs2 = 32'h8001; v.e_ldr = 1; tbl.push_back(v);
    v = blank(); v.rs1 = 5'd4; v.rs2 = 5'd8; v.alu_we = 1; v.alu_rd = 5'd4; v.alu_wdata = 32'hDEAD_BEEF;
    v.e_rs1 = 32'hDEAD_BEEF; v.e_rs2 = 32'h8001; v.e_ldr = 0; tbl.push_back(v);
    v = blank(); v.rs1 = 5'd0; v.rs2 = 5'd4; v.alu_we = 1; v.alu_rd = 5'd0; v.alu_wdata = 32'hFFFF_FFFF;
    v.e_rs2 = 32'hDEAD_BEEF; v.e_ldr = 0; tbl.push_back(v);
    v = blank(); v.st_req = 1; v.st_rs = 5'd4; tbl.push_back(v);
    v = blank(); v.e_sv = 1; v.e_sd = 32'hDEAD_BEEF; v.e_srr = 0; tbl.push_back(v);
    v.st_req = 1; v.st_rs = 5'd3; tbl.push_back(v);
    tbl.push_back(v);
    v = blank(); v.st_ready = 1; v.e_sv = 1; v.e_sd = 32'hDEAD_BEEF; tbl.push_back(v);
    v = blank(); v.e_sd = 32'hDEAD_BEEF; tbl.push_back(v);
    v = blank(); v.st_req = 1; v.st_rs = 5'd3; v.st_ready = 1; v.e_sd = 32'hDEAD_BEEF; tbl.push_back(v);
    v = blank(); v.st_req = 1; v.st_rs = 5'd8; v.st_ready = 1; v.e_sv = 1; v.e_sd = 32'h1234; tbl.push_back(v);
    v = blank(); v.st_ready = 1; v.e_sv = 1; v.e_sd = 32'h8001; tbl.push_back(v);
    v = blank(); v.rs1 = 5'd9; v.lui_en = 1; v.lui_rd = 5'd9; v.lui_imm = 20'h12345;
    v.alu_we = 1; v.alu_rd = 5'd9; v.alu_wdata = 32'hFFFF;
    v.e_rs1 = 32'h1234_5000; v.e_ldr = 0; v.e_sd = 32'h8001; tbl.push_back(v);
    v = blank(); v.rs1 = 5'd9; v.e_rs1 = 32'h1234_5000; v.e_sd = 32'h8001; tbl.push_back(v);
    v = blank(); v.rs1 = 5'd10; v.lui_en = 1; v.lui_rd = 5'd10; v.lui_imm = 20'h80000;
    v.e_rs1 = 32'h8000_0000; v.e_ldr = 0; v.e_sd = 32'h8001; tbl.push_back(v);
    v = blank(); v.rs1 = 5'd11; v.ld_issue = 1; v.ld_issue_rd = 5'd11; v.e_rs1 = 32'd11;
    v.e_sd = 32'h8001; tbl.push_back(v);
    v = blank(); v.rs1 = 5'd11; v.rs2 = 5'd10; v.ld_issue = 1; v.ld_issue_rd = 5'd11;
    v.ld_valid = 1; v.ld_rd = 5'd11; v.f3 = F3_LW; v.rdata = 32'hCAFE_F00D;
    v.e_rs1 = 32'hCAFE_F00D; v.e_rs2 = 32'h8000_0000; v.e_busy1 = 1; v.e_sd = 32'h8001; tbl.push_back(v);
    v = blank(); v.rs1 = 5'd11; v.e_rs1 = 32'hCAFE_F00D; v.e_busy1 = 1; v.e_sd = 32'h8001; tbl.push_back(v);
    v = blank(); v.rs1 = 5'd11; v.ld_issue = 1; v.ld_issue_rd = 5'd0;
    v.ld_valid = 1; v.ld_rd = 5'd11; v.f3 = F3_LH; v.lo = 2'd0; v.rdata = 32'h0000_8001;
    v.e_rs1 = 32'hFFFF_8001; v.e_busy1 = 1; v.e_sd = 32'h8001; tbl.push_back(v);
    v = blank(); v.rs2 = 5'd11; v.st_req = 1; v.st_rs = 5'd9; v.e_rs2 = 32'hFFFF_8001;
    v.e_sd = 32'h8001; tbl.push_back(v);
    v = blank(); v.rs1 = 5'd11; v.ld_issue = 1; v.ld_issue_rd = 5'd12;
    v.e_rs1 = 32'hFFFF_8001; v.e_sv = 1; v.e_sd = 32'h1234_5000; v.e_srr = 0; tbl.push_back(v);

    // Reset and idle inputs.
    rst_n = 1'b0;
    drive(blank());
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table.
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      #3;
      chk($sformatf("row%0d rs1_data", i), rs1_data, tbl[i].e_rs1);
      chk($sformatf("row%0d rs2_data", i), rs2_data, tbl[i].e_rs2);
      chk($sformatf("row%0d rs1_busy", i), {31'd0, rs1_busy}, {31'd0, tbl[i].e_busy1});
      chk($sformatf("row%0d ld_ready", i), {31'd0, ld_ready}, {31'd0, tbl[i].e_ldr});
      chk($sformatf("row%0d st_req_ready", i), {31'd0, st_req_ready}, {31'd0, tbl[i].e_srr});
      chk($sformatf("row%0d st_valid", i), {31'd0, st_valid}, {31'd0, tbl[i].e_sv});
      chk($sformatf("row%0d st_data", i), st_data, tbl[i].e_sd);
      @(posedge clk);
      #1;
    end

    // Stalled store with x12 busy, then asynchronous reset mid-cycle.
    v = blank(); v.rs1 = 5'd9; v.rs2 = 5'd12; drive(v);
    #2;
    chk("prereset st_valid", {31'd0, st_valid}, 32'd1);
    chk("prereset rs2_busy", {31'd0, rs2_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset st_valid", {31'd0, st_valid}, 32'd0);
    chk("midreset st_data", st_data, 32'd0);
    chk("midreset rs1_data x9", rs1_data, 32'd9);
    chk("midreset rs2_busy", {31'd0, rs2_busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();

    // Random traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      v = blank();
      v.rs1 = 5'($urandom_range(0, 31));
      v.rs2 = 5'($urandom_range(0, 31));
      v.alu_we = ($urandom_range(0, 9) < 3);
      v.alu_rd = 5'($urandom_range(0, 31));
      v.alu_wdata = $urandom;
      v.lui_en = ($urandom_range(0, 9) == 0);
      v.lui_rd = 5'($urandom_range(0, 31));
      v.lui_imm = 20'($urandom);
      v.ld_issue = ($urandom_range(0, 9) < 3);
      v.ld_issue_rd = 5'($urandom_range(0, 31));
      v.ld_valid = ($urandom_range(0, 9) < 4);
      v.ld_rd = 5'($urandom_range(0, 31));
      v.f3 = 3'($urandom_range(0, 7));
      v.lo = 2'($urandom_range(0, 3));
      v.rdata = $urandom;
      v.st_req = $urandom_range(0, 1);
      v.st_rs = 5'($urandom_range(0, 31));
      v.st_ready = $urandom_range(0, 1);
      drive(v);

      ldr = !(v.lui_en || v.alu_we);
      m_we = 1'b1;
      if (v.lui_en) begin
        m_wrd = v.lui_rd; m_wv = {v.lui_imm, 12'h000};
      end else if (v.alu_we) begin
        m_wrd = v.alu_rd; m_wv = v.alu_wdata;
      end else if (v.ld_valid) begin
        m_wrd = v.ld_rd;  m_wv = m_align(v.f3, v.lo, v.rdata);
      end else begin
        m_we = 1'b0; m_wrd = 5'd0; m_wv = 32'd0;
      end
      srr = !m_sv || v.st_ready;

      #3;
      chk("rand rs1_data", rs1_data, m_read(v.rs1));
      chk("rand rs2_data", rs2_data, m_read(v.rs2));
      chk("rand rs1_busy", {31'd0, rs1_busy}, {31'd0, m_busy[v.rs1]});
      chk("rand rs2_busy", {31'd0, rs2_busy}, {31'd0, m_busy[v.rs2]});
      chk("rand ld_ready", {31'd0, ld_ready}, {31'd0, ldr});
      chk("rand st_req_ready", {31'd0, st_req_ready}, {31'd0, srr});
      chk("rand st_valid", {31'd0, st_valid}, {31'd0, m_sv});
      chk("rand st_data", st_data, m_sd);

      // Advance the model to the post-edge state.
      if (v.st_req && srr) begin
        m_sv = 1'b1;
        m_sd = m_read(v.st_rs);
      end else if (v.st_ready) begin
        m_sv = 1'b0;
      end
      if (m_we && m_wrd != 5'd0) m_reg[m_wrd] = m_wv;
      if (v.ld_valid && ldr) m_busy[v.ld_rd] = 1'b0;
      if (v.ld_issue) m_busy[v.ld_issue_rd] = 1'b1;
      m_busy[0] = 1'b0;

      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb.md
# regfile_wb

Parametrised integer register file with a single arbitrated write-back port, load-data alignment/extension, a load scoreboard and a one-entry store-data buffer with valid/ready handshake toward data memory. Sits between decode (two combinational read ports), execute (ALU/LUI write-back) and the data-memory interface (load return, store data). Register x0 is hard-wired to zero.

## Interface
- `XLEN`, 32, register and data width (≥16, multiple of 8).
- `NREG`, 32, number of registers (power of two, ≥2).
- `AW`, $clog2(NREG), register index width (derived, not overridden).
- `RST_IDX`, 1, 1: register i resets to value i (x0 = 0); 0: all registers reset to 0.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rs1_addr`, `rs2_addr` in AW: read indices.
- `rs1_data`, `rs2_data` out XLEN: read data, write-first bypassed.
- `rs1_busy`, `rs2_busy` out 1: scoreboard bit of addressed register.
- `alu_we` in 1, `alu_rd` in AW, `alu_wdata` in XLEN: ALU write-back.
- `lui_en` in 1, `lui_rd` in AW, `lui_imm` in 20: LUI write-back, value = {lui_imm, 12'b0} sign-extended to XLEN.
- `ld_issue` in 1, `ld_issue_rd` in AW: load issued to memory; marks rd busy.
- `ld_valid` in 1, `ld_ready` out 1: load return handshake.
- `ld_rd` in AW, `ld_funct3` in 3, `ld_addr_lo` in 2, `ld_rdata` in XLEN: load return payload.
- `st_req` in 1, `st_rs` in AW, `st_req_ready` out 1: store data request.
- `st_valid` out 1, `st_data` out XLEN, `st_ready` in 1: store data to memory.

## Operation
- Write priority per cycle: `lui_en` > `alu_we` > load return. At most one register written per cycle.
- `ld_ready` = !(lui_en | alu_we); load completes on `ld_valid & ld_ready`.
- Load alignment by `ld_funct3`: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; byte lane = `ld_addr_lo`, half lane = `ld_addr_lo[1]`; signed forms sign-extend, U forms zero-extend. Other funct3 codes: write the full word unchanged.
- Writes to x0 discarded; reads of x0 return 0; x0 never busy.
- Bypass: if the committing write's rd equals a read index (≠0), the read port returns the write data in the same cycle.
- Scoreboard: `ld_issue` sets busy[ld_issue_rd] at the edge; completed load clears busy[ld_rd]. Issue and completion to the same register in one cycle: bit stays set.
- Store buffer: `st_req_ready` = !st_valid | st_ready. On `st_req & st_req_ready`, captures bypassed value of `st_rs` into `st_data`, sets `st_valid`. `st_valid` clears on `st_ready` without new request; back-to-back accepted when `st_ready` high.
- `lui_en` and `alu_we` together: LUI written, ALU value dropped (upstream protocol error, no flag).

## Timing
- Reads, `rs*_busy`, `ld_ready`, `st_req_ready`: combinational.
- Register writes, busy updates, store capture: visible after next rising edge (1-cycle latency).
- Reset (any time, including mid-handshake): registers per `RST_IDX`, busy all 0, `st_valid` 0, `st_data` 0; pending load/store discarded.
- `st_data` stable while `st_valid & !st_ready`.

## Structure
- Package `regfile_pkg`: load funct3 localparams (LB/LH/LW/LBU/LHU), LUI shift constant 12.
- Sub-module `load_align`: combinational lane select and sign/zero extension (funct3, addr_lo, rdata → XLEN).
- Top holds register array, write arbiter, bypass muxes, busy vector, store buffer.

## Test plan
- Reset release, RST_IDX=1: read x5 → 5, x0 → 0; st_valid 0; all busy 0.
- `ld_issue` rd=7; return LB, addr_lo=2, rdata=0x0080_0000 → x7 = 0xFFFF_FF80, busy[7] set then cleared.
- Load return concurrent with alu_we rd=3, 0x1234 → ld_ready 0, x3=0x1234; load written next cycle.
- alu_we rd=4, 0xDEAD_BEEF with rs1_addr=4 same cycle → rs1_data 0xDEAD_BEEF; write to x0 → x0 stays 0.
- st_req rs=4 with st_ready 0 for 3 cycles → st_valid held, st_data 0xDEAD_BEEF, st_req_ready 0; st_ready 1 → drains.
- lui_en rd=9, imm=0x12345 → x9 = 0x1234_5000; rst_n low mid-store → st_valid 0 immediately.
